// File: rtl/sample_buffer_reader.sv
// sample_buffer_reader: walks a range of 48-bit words on RAM port B and
// streams each word as six little-endian bytes over a valid/ready byte port.
// Latency: first byte 3 cycles after an accepted start; 8 cycles per word
// when tx_ready stays high. A stalled byte holds until it is accepted.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start, i_start_addr,    start pulse, first word address and number of
//   i_word_count              words (0..512); start is ignored unless idle
//   o_busy, o_done            transfer in progress / one-cycle completion pulse
//   o_adb, o_ceb, o_oce       RAM port-B address, read strobe, output enable
//   i_ram_dout                RAM port-B data, valid the cycle after o_ceb
//   o_tx_data, o_tx_valid,    byte stream toward the transmitter
//   i_tx_ready
module sample_buffer_reader (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [8:0]  i_start_addr,
  input  logic [9:0]  i_word_count,
  output logic        o_busy,
  output logic        o_done,
  output logic [8:0]  o_adb,
  output logic        o_ceb,
  output logic        o_oce,
  input  logic [47:0] i_ram_dout,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_FIN
  } state_t;

  state_t      r_state;
  logic [8:0]  r_addr;       // next word to read; wraps naturally at 512
  logic [9:0]  r_remaining;  // words not yet latched
  logic [47:0] r_shift;      // current word, lowest byte presented first
  logic [2:0]  r_byte_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_ceb;
  logic [8:0]  r_adb;
  logic        r_tx_valid;
  logic        w_hs;

  assign w_hs       = r_tx_valid && i_tx_ready;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_adb      = r_adb;
  assign o_ceb      = r_ceb;
  assign o_oce      = 1'b1;
  // The shift register empties to zero after the sixth byte, so tx_data
  // reads 0 whenever nothing is being sent.
  assign o_tx_data  = r_shift[7:0];
  assign o_tx_valid = r_tx_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= 9'd0;
      r_remaining <= 10'd0;
      r_shift     <= 48'd0;
      r_byte_idx  <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ceb       <= 1'b0;
      r_adb       <= 9'd0;
      r_tx_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr      <= i_start_addr;
            r_remaining <= i_word_count;
            if (i_word_count == 10'd0) begin
              // Empty transfer: completion pulse only, busy never rises.
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              // Outputs are registered, so the read strobe for the first
              // word is set up here to appear in the READ cycle.
              r_state <= S_READ;
              r_busy  <= 1'b1;
              r_ceb   <= 1'b1;
              r_adb   <= i_start_addr;
            end
          end
        end

        S_READ: begin
          r_ceb   <= 1'b0;
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_shift     <= i_ram_dout;
          r_byte_idx  <= 3'd0;
          r_addr      <= r_addr + 9'd1;
          r_remaining <= r_remaining - 10'd1;
          r_tx_valid  <= 1'b1;
          r_state     <= S_SEND;
        end

        S_SEND: begin
          if (w_hs) begin
            r_shift    <= {8'd0, r_shift[47:8]};
            r_byte_idx <= r_byte_idx + 3'd1;
            if (r_byte_idx == 3'd5) begin
              r_tx_valid <= 1'b0;
              if (r_remaining != 10'd0) begin
                r_state <= S_READ;
                r_ceb   <= 1'b1;
                r_adb   <= r_addr;
              end else begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Bench for sample_buffer_reader: RAM model on port B, byte scoreboard fed at
// start time, and per-cycle tracking of strobes, done pulses and stalls.
module tb_sample_buffer_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  start_addr;
  logic [9:0]  word_count;
  logic        busy;
  logic        done;
  logic [8:0]  adb;
  logic        ceb;
  logic        oce;
  logic [47:0] ram_dout = 48'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  sample_buffer_reader dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_word_count (word_count),
    .o_busy       (busy),
    .o_done       (done),
    .o_adb        (adb),
    .o_ceb        (ceb),
    .o_oce        (oce),
    .i_ram_dout   (ram_dout),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready)
  );

  // RAM port B, bypass mode: data for a strobed address appears next cycle.
  logic [47:0] mem [512];
  always @(posedge clk) if (ceb) ram_dout <= mem[adb];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int t0      = 0;
  int hs_cnt, done_cnt, first_valid, done_cyc;
  bit busy_seen, stalled, rnd_ready;
  logic [7:0] held;
  logic [7:0] exp_q [$];
  int adb_q [$];
  int ceb_cyc_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    adb_q.delete();
    ceb_cyc_q.delete();
    hs_cnt      = 0;
    done_cnt    = 0;
    first_valid = -1;
    done_cyc    = -1;
    busy_seen   = 1'b0;
  endtask

  // Advance one cycle, observe at #1 after the edge, drive tx_ready, and
  // score any handshake that the coming edge will complete.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (stalled) begin
      chk("stall_valid", 64'(tx_valid), 64'd1);
      chk("stall_data", 64'(tx_data), 64'(held));
    end
    if (ceb) begin
      adb_q.push_back(int'(adb));
      ceb_cyc_q.push_back(cyc);
    end
    if (tx_valid && first_valid < 0) first_valid = cyc;
    if (busy) busy_seen = 1'b1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", 64'(busy), 64'd0);
    end
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (tx_valid && tx_ready) begin
      hs_cnt++;
      chk("sb_has_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("byte", 64'(tx_data), 64'(exp_q.pop_front()));
    end
    stalled = tx_valid && !tx_ready && !reset;
    held    = tx_data;
  endtask

  // Drive a one-cycle start and, if asked, queue the bytes it should produce.
  task automatic kick(input int a, input int wc, input bit push);
    start      = 1'b1;
    start_addr = 9'(a);
    word_count = 10'(wc);
    if (push)
      for (int w = 0; w < wc; w++)
        for (int b = 0; b < 6; b++)
          exp_q.push_back(mem[(a + w) % 512][8*b +: 8]);
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    chk("done_within_bound", 64'(done_cnt > 0), 64'd1);
  endtask

  task automatic chk_adb(input string tag, input int base, input int n);
    chk({tag, "_count"}, 64'(adb_q.size()), 64'(n));
    for (int k = 0; k < n; k++)
      chk(tag, 64'(adb_q.size() > k ? adb_q[k] : -1), 64'((base + k) % 512));
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      mem[i] = {8'(i), 8'(i * 3), 8'(i ^ 8'h5A), 8'(i + 8'h11), 8'(i * 5 + 1), 8'(~i)};
    mem[0] = 48'h0123_4567_89AB;

    reset = 1'b1; start = 1'b0; start_addr = 9'd0; word_count = 10'd0;
    tx_ready = 1'b1; rnd_ready = 1'b0; stalled = 1'b0; held = 8'd0;
    clr();
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_ceb", 64'(ceb), 64'd0);
    chk("rst_adb", 64'(adb), 64'd0);
    chk("rst_oce", 64'(oce), 64'd1);
    reset = 1'b0;
    tick();

    // Single word at address 0: exact cycle placement.
    clr();
    kick(0, 1, 1'b1);
    chk("t1_busy_T+1", 64'(busy), 64'd1);
    wait_done(40);
    chk("t1_first_valid", 64'(first_valid - t0), 64'd3);
    chk("t1_done_cyc", 64'(done_cyc - t0), 64'd9);
    chk("t1_ceb_count", 64'(ceb_cyc_q.size()), 64'd1);
    chk("t1_ceb_cyc", 64'(ceb_cyc_q.size() == 1 ? ceb_cyc_q[0] - t0 : -1), 64'd1);
    chk_adb("t1_adb", 0, 1);
    repeat (3) tick();
    chk("t1_bytes", 64'(hs_cnt), 64'd6);
    chk("t1_done_once", 64'(done_cnt), 64'd1);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Address wrap 510 -> 1.
    clr();
    kick(510, 4, 1'b1);
    wait_done(200);
    repeat (3) tick();
    chk_adb("t2_adb", 510, 4);
    chk("t2_bytes", 64'(hs_cnt), 64'd24);
    chk("t2_done_once", 64'(done_cnt), 64'd1);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Random backpressure.
    rnd_ready = 1'b1;
    clr();
    kick(200, 5, 1'b1);
    wait_done(2000);
    rnd_ready = 1'b0;
    repeat (3) tick();
    chk_adb("t3_adb", 200, 5);
    chk("t3_bytes", 64'(hs_cnt), 64'd30);
    chk("t3_done_once", 64'(done_cnt), 64'd1);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length transfer.
    clr();
    kick(33, 0, 1'b1);
    repeat (4) tick();
    chk("t4_done_cyc", 64'(done_cyc - t0), 64'd1);
    chk("t4_done_once", 64'(done_cnt), 64'd1);
    chk("t4_busy_never", 64'(busy_seen), 64'd0);
    chk("t4_no_ceb", 64'(ceb_cyc_q.size()), 64'd0);
    chk("t4_no_valid", 64'(first_valid < 0), 64'd1);

    // Start while busy is ignored.
    clr();
    kick(100, 2, 1'b1);
    repeat (4) tick();
    start = 1'b1; start_addr = 9'd300; word_count = 10'd3;
    tick();
    start = 1'b0;
    wait_done(200);
    repeat (10) tick();
    chk_adb("t5_adb", 100, 2);
    chk("t5_bytes", 64'(hs_cnt), 64'd12);
    chk("t5_done_once", 64'(done_cnt), 64'd1);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t5_idle_busy", 64'(busy), 64'd0);

    // Reset during the third byte of the second word.
    clr();
    kick(50, 3, 1'b1);
    for (int n = 0; n < 100 && hs_cnt < 9; n++) tick();
    chk("t6_reached_byte9", 64'(hs_cnt), 64'd9);
    reset = 1'b1;
    tick();
    chk("t6_tx_valid", 64'(tx_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ceb", 64'(ceb), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_tx_data", 64'(tx_data), 64'd0);
    chk("t6_adb", 64'(adb), 64'd0);
    chk("t6_oce", 64'(oce), 64'd1);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    clr();
    kick(7, 2, 1'b1);
    wait_done(200);
    repeat (3) tick();
    chk_adb("t6_adb_restart", 7, 2);
    chk("t6_bytes", 64'(hs_cnt), 64'd12);
    chk("t6_done_once", 64'(done_cnt), 64'd1);
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sample_buffer_reader.md
# sample_buffer_reader

Read side of the 12-bit-in / 48-bit-out sample buffer RAM. After a capture completes, this block walks a range of 48-bit RAM words through the read port (port B), unpacks each word into six bytes, and presents them on a byte stream with valid/ready handshake toward the UART/host transmitter. It owns port-B control (address, clock enable, output enable) and reports busy/done to the capture sequencer.

## Interface
Parameters:
- none (widths fixed by the RAM geometry: 512 words x 48 bits on the read port)

Ports:
- clk  input  1  single clock for all logic and RAM port B
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse; begins a transfer when idle
- start_addr  input  9  first RAM word address, sampled on accepted start
- word_count  input  10  number of 48-bit words to send, 0..512, sampled on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the transfer finishes
- adb  output  9  RAM port-B word address
- ceb  output  1  RAM port-B clock enable (read strobe)
- oce  output  1  RAM output-register enable; tied high
- ram_dout  input  48  RAM port-B data; bypass read mode, valid the cycle after ceb
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready

## Operation
- Word layout: ram_dout = {s3,s2,s1,s0}, s0 = ram_dout[11:0] is the earliest sample (lowest write address).
- Byte order per word is little-endian: ram_dout[7:0], [15:8], [23:16], [31:24], [39:32], [47:40].
- FSM states: IDLE, READ, LATCH, SEND, FIN.
- IDLE: on start, load addr<=start_addr, remaining<=word_count. If word_count==0 go to FIN; else go to READ.
- READ (1 cycle): ceb=1, adb=addr. Next state LATCH.
- LATCH (1 cycle): capture ram_dout into 48-bit shift register, byte_idx<=0, addr<=addr+1 (mod 512, 511 wraps to 0), remaining<=remaining-1. Next state SEND.
- SEND: tx_valid=1, tx_data=shift[7:0]. On handshake: shift right by 8, byte_idx+1. On handshake with byte_idx==5: go to READ if remaining!=0, else FIN.
- FIN (1 cycle): done=1, busy=0 thereafter; return to IDLE.
- start while not in IDLE is ignored (no restart, no parameter resample).
- ceb is high only in READ; adb holds its last value otherwise.
- Total bytes emitted = 6 x word_count.

## Timing
- Reset values: busy=0, done=0, tx_valid=0, tx_data=0, ceb=0, adb=0, oce=1; FSM=IDLE, shift register and counters 0.
- Reset mid-transfer: next cycle all outputs at reset values; in-flight byte is dropped; no done pulse.
- start accepted in cycle T: busy=1 from T+1; ceb=1 at T+1; first tx_valid at T+3.
- RAM latency: word read with ceb at cycle N is captured from ram_dout at N+1.
- Per word, minimum 8 cycles (READ, LATCH, 6 SEND with tx_ready held high); 2 idle cycles between words on the stream.
- tx_data and tx_valid stay stable while tx_valid && !tx_ready; tx_valid never drops without a handshake.
- done asserts one cycle after the final byte's handshake; busy falls in the same cycle as done.
- word_count==0: done at T+1, busy never asserts, no ceb, no tx_valid.

## Test plan
- RAM model word 0 = 48'h0123_4567_89AB, start_addr=0, word_count=1, tx_ready=1 -> bytes AB,89,67,45,23,01 on T+3..T+8, done at T+9, ceb high only at T+1 with adb=0.
- start_addr=510, word_count=4 -> adb sequence 510,511,0,1; 24 bytes in order; done once.
- Backpressure: tx_ready toggles 1/0 randomly -> tx_data stable while stalled, byte sequence identical to no-stall run.
- word_count=0 -> done pulse at T+1, busy stays 0, no ceb, no tx_valid.
- start pulsed again mid-transfer with different start_addr -> ignored; original sequence completes unchanged.
- reset asserted during third byte of second word -> next cycle tx_valid=0, busy=0, ceb=0, no done; fresh start afterwards runs correctly from its start_addr.
